// File: rtl/led_bar_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_bar_ctrl
//  Description : Turns a stream of 12-bit mic samples into a windowed peak
//                level (0-15) with a peak-hold/decay marker, and shares the
//                LED bar between the meter and one override requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_bar_ctrl #(
    parameter int BASE      = 2048,  // unsigned sample value meaning silence
    parameter int WIN       = 1024,  // valid samples per window (>= 2)
    parameter int HOLD_WIN  = 4,     // windows the marker holds before decay
    parameter int DECAY_WIN = 2      // windows between marker decrements
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    input  logic        ovr_req,
    input  logic [3:0]  ovr_num,
    output logic        ovr_gnt,
    output logic [3:0]  num,
    output logic [3:0]  peak,
    output logic        win_done
);

    localparam int             c_CNT_W   = (WIN > 2) ? $clog2(WIN) : 1;
    localparam int             c_HCNT_W  = (HOLD_WIN > 1) ? $clog2(HOLD_WIN + 1) : 1;
    localparam int             c_DCNT_W  = (DECAY_WIN > 1) ? $clog2(DECAY_WIN + 1) : 1;
    localparam logic [11:0]    c_BASE    = 12'(BASE);
    localparam logic [c_CNT_W-1:0]  c_WIN_LAST = c_CNT_W'(WIN - 1);
    localparam logic [c_HCNT_W-1:0] c_HOLD     = c_HCNT_W'(HOLD_WIN);
    localparam logic [c_DCNT_W-1:0] c_DECAY    = c_DCNT_W'(DECAY_WIN);

    typedef enum logic [1:0] {
        S_TRACK = 2'd0,
        S_HOLD  = 2'd1,
        S_DECAY = 2'd2
    } state_t;

    // window accumulation
    logic [c_CNT_W-1:0]  r_cnt;
    logic [3:0]          r_wmax;
    logic [3:0]          r_bar;
    logic                r_win_done;

    // peak marker FSM
    state_t              r_state, w_state_nxt;
    logic [3:0]          r_pk, w_pk_nxt;
    logic [c_HCNT_W-1:0] r_hcnt, w_hcnt_nxt, w_hcnt_inc;
    logic [c_DCNT_W-1:0] r_dcnt, w_dcnt_nxt, w_dcnt_inc;
    logic [3:0]          w_pk_dec;

    // output registers
    logic                r_gnt;
    logic [3:0]          r_num;
    logic [3:0]          r_peak_o;

    // combinational datapath
    logic [11:0]         w_mag;
    logic [3:0]          w_lvl;
    logic [3:0]          w_wmax_upd;
    logic                w_close;
    logic [3:0]          w_bar_nxt;
    logic                w_unused_mag;

    // Distance from silence; anything at or beyond 2048 saturates to level 15
    always_comb begin
        w_mag = (sample >= c_BASE) ? (sample - c_BASE) : (c_BASE - sample);
        w_lvl = w_mag[11] ? 4'hF : w_mag[10:7];
    end

    assign w_unused_mag = ^w_mag[6:0];
    assign w_wmax_upd   = (w_lvl > r_wmax) ? w_lvl : r_wmax;
    assign w_close      = sample_valid && (r_cnt == c_WIN_LAST);
    assign w_bar_nxt    = w_close ? w_wmax_upd : r_bar;

    // Window counter and running max; the closing sample counts toward its window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_wmax     <= 4'd0;
            r_bar      <= 4'd0;
            r_win_done <= 1'b0;
        end else begin
            r_win_done <= w_close;
            if (sample_valid) begin
                if (w_close) begin
                    r_cnt  <= '0;
                    r_wmax <= 4'd0;
                    r_bar  <= w_wmax_upd;
                end else begin
                    r_cnt  <= r_cnt + c_CNT_W'(1);
                    r_wmax <= w_wmax_upd;
                end
            end
        end
    end

    // Peak FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_TRACK;
            r_pk    <= 4'd0;
            r_hcnt  <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pk    <= w_pk_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // Peak FSM next state: only advances when a window closes
    always_comb begin
        w_state_nxt = r_state;
        w_pk_nxt    = r_pk;
        w_hcnt_nxt  = r_hcnt;
        w_dcnt_nxt  = r_dcnt;
        w_hcnt_inc  = r_hcnt + c_HCNT_W'(1);
        w_dcnt_inc  = r_dcnt + c_DCNT_W'(1);
        w_pk_dec    = r_pk - 4'd1;
        if (w_close) begin
            case (r_state)
                S_TRACK: begin
                    if (w_bar_nxt < r_pk) begin
                        w_state_nxt = S_HOLD;
                        w_hcnt_nxt  = '0;
                    end else begin
                        w_pk_nxt    = w_bar_nxt;
                    end
                end
                S_HOLD: begin
                    if (w_bar_nxt > r_pk) begin
                        w_pk_nxt    = w_bar_nxt;
                        w_hcnt_nxt  = '0;
                    end else if (w_hcnt_inc == c_HOLD) begin
                        w_state_nxt = S_DECAY;
                        w_hcnt_nxt  = '0;
                        w_dcnt_nxt  = '0;
                    end else begin
                        w_hcnt_nxt  = w_hcnt_inc;
                    end
                end
                S_DECAY: begin
                    if (w_bar_nxt >= r_pk) begin
                        // a strictly higher level restarts the hold period
                        w_pk_nxt    = w_bar_nxt;
                        w_hcnt_nxt  = '0;
                        w_dcnt_nxt  = '0;
                        w_state_nxt = (w_bar_nxt > r_pk) ? S_HOLD : S_TRACK;
                    end else if (w_dcnt_inc == c_DECAY) begin
                        w_dcnt_nxt = '0;
                        if (w_pk_dec <= w_bar_nxt) begin
                            w_pk_nxt    = w_bar_nxt;
                            w_state_nxt = S_TRACK;
                        end else begin
                            w_pk_nxt    = w_pk_dec;
                        end
                    end else begin
                        w_dcnt_nxt = w_dcnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_TRACK;
                end
            endcase
        end
    end

    // Output mux: the grant decided this cycle selects what the bar shows next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt    <= 1'b0;
            r_num    <= 4'd0;
            r_peak_o <= 4'd0;
        end else begin
            r_gnt    <= ovr_req;
            r_num    <= ovr_req ? ovr_num : w_bar_nxt;
            r_peak_o <= ovr_req ? 4'd0    : w_pk_nxt;
        end
    end

    assign ovr_gnt  = r_gnt;
    assign num      = r_num;
    assign peak     = r_peak_o;
    assign win_done = r_win_done;

endmodule
`default_nettype wire

// File: tb/tb_led_bar_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_bar_ctrl
//  Description : Self-checking bench for led_bar_ctrl (WIN=4, HOLD_WIN=4,
//                DECAY_WIN=2) using an expected-result queue per window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_bar_ctrl;

    localparam logic [11:0] SIL = 12'd2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] sample = 12'd2048;
    logic        ovr_req = 1'b0;
    logic [3:0]  ovr_num = 4'd0;
    logic        ovr_gnt;
    logic [3:0]  num;
    logic [3:0]  peak;
    logic        win_done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];

    led_bar_ctrl #(
        .BASE(2048), .WIN(4), .HOLD_WIN(4), .DECAY_WIN(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .ovr_req(ovr_req), .ovr_num(ovr_num), .ovr_gnt(ovr_gnt),
        .num(num), .peak(peak), .win_done(win_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input logic [11:0] s);
        sample_valid = 1'b1;
        sample       = s;
        tick();
        sample_valid = 1'b0;
    endtask

    // queue the expected bar/marker, then drive one full window
    task automatic send_window(input logic [11:0] s0, input logic [11:0] s1,
                               input logic [11:0] s2, input logic [11:0] s3,
                               input logic [3:0] en, input logic [3:0] ep);
        exp_q.push_back({en, ep});
        drive_sample(s0);
        drive_sample(s1);
        drive_sample(s2);
        drive_sample(s3);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (win_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ovr_gnt, win_done, num, peak} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_async: got gnt=%b done=%b num=%0d peak=%0d, expected all 0", ovr_gnt, win_done, num, peak);
        end
        repeat (3) tick();
        n_checks++;
        if ({ovr_gnt, win_done, num, peak} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got gnt=%b done=%b num=%0d peak=%0d, expected all 0", ovr_gnt, win_done, num, peak);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_window();
        bit ok;
        logic [7:0] exp;
        send_window(SIL, SIL + 12'd900, SIL, SIL - 12'd300, 4'd7, 4'd7);
        wait_done(ok);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL window_timeout: win_done never seen, expected num=%0d peak=%0d", exp[7:4], exp[3:0]);
        end else if ({num, peak} !== exp) begin
            n_fail++;
            $display("FAIL window_basic: got num=%0d peak=%0d, expected num=%0d peak=%0d", num, peak, exp[7:4], exp[3:0]);
        end
        tick();
        n_checks++;
        if (win_done !== 1'b0) begin
            n_fail++;
            $display("FAIL win_done_pulse: got %b, expected 0", win_done);
        end
        repeat (6) tick();
        n_checks++;
        if ({num, peak} !== {4'd7, 4'd7}) begin
            n_fail++;
            $display("FAIL idle_hold: got num=%0d peak=%0d, expected num=7 peak=7", num, peak);
        end
    endtask

    task automatic test_boundaries();
        bit ok;
        logic [7:0]  exp;
        logic [11:0] s[4][4];
        logic [3:0]  en[4];
        logic [3:0]  ep[4];
        s  = '{'{12'd0, SIL, SIL, SIL}, '{SIL, SIL, SIL, 12'd4095},
               '{12'd2175, SIL, SIL, SIL}, '{12'd2176, SIL, SIL, SIL}};
        en = '{4'd15, 4'd15, 4'd0, 4'd1};
        ep = '{4'd15, 4'd15, 4'd15, 4'd15};
        for (int i = 0; i < 4; i++) begin
            send_window(s[i][0], s[i][1], s[i][2], s[i][3], en[i], ep[i]);
            wait_done(ok);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL boundary_timeout_%0d: win_done never seen, expected num=%0d", i, exp[7:4]);
            end else if ({num, peak} !== exp) begin
                n_fail++;
                $display("FAIL boundary_%0d: got num=%0d peak=%0d, expected num=%0d peak=%0d", i, num, peak, exp[7:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] exp;
        ovr_num = 4'd9;
        ovr_req = 1'b1;
        tick();
        n_checks++;
        if ({ovr_gnt, num} !== {1'b1, 4'd9}) begin
            n_fail++;
            $display("FAIL pre_reset_grant: got gnt=%b num=%0d, expected gnt=1 num=9", ovr_gnt, num);
        end
        drive_sample(12'd0);
        drive_sample(12'd0);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ovr_gnt, win_done, num, peak} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got gnt=%b done=%b num=%0d peak=%0d, expected all 0", ovr_gnt, win_done, num, peak);
        end
        ovr_req = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        // a leftover partial window would close early with level 15
        send_window(SIL + 12'd1000, SIL, SIL, SIL, 4'd7, 4'd7);
        wait_done(ok);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_mid_timeout: win_done never seen, expected num=%0d", exp[7:4]);
        end else if ({num, peak} !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_window: got num=%0d peak=%0d, expected num=%0d peak=%0d", num, peak, exp[7:4], exp[3:0]);
        end
    endtask

    task automatic test_decay();
        bit ok;
        logic [7:0]  exp;
        int          ep;
        for (int k = 1; k <= 31; k++) begin
            if (k == 1) begin
                ep = 12;
            end else if (k <= 7) begin
                ep = 12;
            end else begin
                ep = 12 - (k - 6) / 2;
                if (ep < 0) ep = 0;
            end
            if (k == 1) send_window(SIL + 12'd1536, SIL, SIL, SIL, 4'd12, 4'(ep));
            else        send_window(SIL, SIL, SIL, SIL, 4'd0, 4'(ep));
            wait_done(ok);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL decay_timeout_%0d: win_done never seen, expected peak=%0d", k, exp[3:0]);
            end else if ({num, peak} !== exp) begin
                n_fail++;
                $display("FAIL decay_%0d: got num=%0d peak=%0d, expected num=%0d peak=%0d", k, num, peak, exp[7:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_decay_recover();
        bit ok;
        logic [7:0]  exp;
        logic [3:0]  lv;
        logic [3:0]  ep[20];
        ep = '{4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd11, 4'd11, 4'd10,
               4'd10, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd8};
        for (int k = 1; k <= 20; k++) begin
            lv = (k == 1) ? 4'd12 : ((k == 12 || k == 13) ? 4'd9 : 4'd0);
            send_window(SIL + {1'b0, lv, 7'd0}, SIL, SIL, SIL, lv, ep[k-1]);
            wait_done(ok);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL recover_timeout_%0d: win_done never seen, expected peak=%0d", k, exp[3:0]);
            end else if ({num, peak} !== exp) begin
                n_fail++;
                $display("FAIL recover_%0d: got num=%0d peak=%0d, expected num=%0d peak=%0d", k, num, peak, exp[7:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_override();
        bit ok;
        logic [7:0] exp;
        ovr_num = 4'd5;
        ovr_req = 1'b1;
        tick();
        n_checks++;
        if ({ovr_gnt, num, peak} !== {1'b1, 4'd5, 4'd0}) begin
            n_fail++;
            $display("FAIL ovr_grant: got gnt=%b num=%0d peak=%0d, expected gnt=1 num=5 peak=0", ovr_gnt, num, peak);
        end
        ovr_num = 4'd13;
        tick();
        n_checks++;
        if (num !== 4'd13) begin
            n_fail++;
            $display("FAIL ovr_track: got num=%0d, expected 13", num);
        end
        send_window(SIL + 12'd400, SIL, SIL, SIL, 4'd13, 4'd0);
        wait_done(ok);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ovr_window_timeout: win_done never seen, expected num=%0d", exp[7:4]);
        end else if ({num, peak} !== exp) begin
            n_fail++;
            $display("FAIL ovr_window: got num=%0d peak=%0d, expected num=%0d peak=%0d", num, peak, exp[7:4], exp[3:0]);
        end
        ovr_req = 1'b0;
        tick();
        n_checks++;
        if ({ovr_gnt, num, peak} !== {1'b0, 4'd3, 4'd8}) begin
            n_fail++;
            $display("FAIL ovr_release: got gnt=%b num=%0d peak=%0d, expected gnt=0 num=3 peak=8", ovr_gnt, num, peak);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] exp;
        ovr_num = 4'd2;
        exp_q.push_back({4'd2, 4'd0});
        drive_sample(SIL + 12'd1280);
        drive_sample(SIL + 12'd1280);
        drive_sample(SIL + 12'd1280);
        ovr_req = 1'b1;
        drive_sample(SIL + 12'd1280);
        wait_done(ok);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_timeout: win_done never seen, expected num=%0d", exp[7:4]);
        end else if ({ovr_gnt, num, peak} !== {1'b1, exp}) begin
            n_fail++;
            $display("FAIL b2b_grant: got gnt=%b num=%0d peak=%0d, expected gnt=1 num=%0d peak=%0d", ovr_gnt, num, peak, exp[7:4], exp[3:0]);
        end
        ovr_req = 1'b0;
        tick();
        n_checks++;
        if ({ovr_gnt, num, peak} !== {1'b0, 4'd10, 4'd10}) begin
            n_fail++;
            $display("FAIL b2b_release: got gnt=%b num=%0d peak=%0d, expected gnt=0 num=10 peak=10", ovr_gnt, num, peak);
        end
    endtask

    initial begin
        test_reset();
        test_window();
        test_boundaries();
        test_reset_mid();
        test_decay();
        test_decay_recover();
        test_override();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/led_bar_ctrl.md
Name: led_bar_ctrl

Overview:
- Sequences the 16-LED thermometer bar decoder; its `num` output drives the decoder's 4-bit `num` input.
- Converts a stream of 12-bit mic samples into a windowed peak level (0-15) with a peak-hold/decay marker.
- Shares the bar between the volume meter (default owner) and one override requester (menu/game) through a req/gnt handshake.
- Sits between the mic sampler and the LED decoder.

Parameters:
- BASE, 2048, mid-scale (silence) value of the unsigned sample.
- WIN, 1024, valid samples per measurement window (must be >= 2).
- HOLD_WIN, 4, windows the peak marker is held before decay starts.
- DECAY_WIN, 2, windows between successive peak decrements.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe, sample is valid
- sample  in  12  unsigned mic sample
- ovr_req  in  1  override requester wants the bar (level-sensitive)
- ovr_num  in  4  level to show while override is granted
- ovr_gnt  out  1  override owns the bar
- num  out  4  bar level to the LED decoder
- peak  out  4  peak-hold marker level (0 while override is granted)
- win_done  out  1  one-cycle pulse when a window closes

Behaviour:
- Reset (async, rst_n=0): all outputs 0. Internal state: window max 0, sample counter 0, bar level 0, peak 0, FSM in TRACK. Registers only; no combinational path from input to output.
- Magnitude: mag = |sample - BASE|, 12-bit; mag = 2048 (sample=0) saturates to 2047. lvl = mag[10:7], giving 0..15.
- Window:
  - On each sample_valid: wmax <= max(wmax, lvl) and the counter increments.
  - On the WIN-th sample the counter wraps to 0 and bar_lvl <= max(wmax, lvl); this sample is included in the closing window.
  - wmax restarts at 0, so the next window starts empty.
  - win_done pulses the following cycle.
  - Latency: last sample of window -> num updated 1 cycle later (meter owns the bar).
- Peak FSM, evaluated only on a window close with the new bar_lvl:
  - TRACK: peak follows bar_lvl. If bar_lvl < previous peak, go to HOLD with hcnt=0; otherwise stay.
  - HOLD: if bar_lvl > peak, peak <= bar_lvl and hcnt=0. Otherwise hcnt++; when hcnt reaches HOLD_WIN, go to DECAY with dcnt=0.
  - DECAY: if bar_lvl >= peak, peak <= bar_lvl and go to TRACK (HOLD if the new peak exceeds the old one). Otherwise dcnt++; at DECAY_WIN, peak-- and dcnt=0; if peak-1 <= bar_lvl, peak <= bar_lvl and go to TRACK.
  - Peak never goes below bar_lvl and never underflows past 0.
- Arbitration:
  - ovr_req=1 with gnt=0: ovr_gnt=1 next cycle. Next cycle num <= ovr_num (registered, tracks ovr_num each cycle) and peak output <= 0.
  - ovr_req=0 with gnt=1: ovr_gnt=0 next cycle; num/peak restore to the current meter values the same cycle.
  - Meter windowing and the peak FSM keep running during override. Windows closing during override update internal state only.
  - A window close and a grant change in the same cycle: grant takes precedence for output muxing, and internal state still updates.
- No sample_valid: all state holds; num/peak stay constant indefinitely.
- Reset mid-window or mid-override: immediate return to reset state. Partial window discarded, gnt dropped.

Test Plan:
- Reset with rst_n low for 3 cycles mid-stream -> num=0, peak=0, ovr_gnt=0, win_done=0, asynchronously on the rst_n fall.
- WIN=4; samples 2048, 2048+900, 2048, 2048-300 -> lvls 0,7,0,2. One cycle after the 4th: num=7, peak=7, win_done=1 for one cycle.
- Boundaries: sample=0 -> lvl 15 (saturated); sample=4095 -> lvl 15; sample=2048+127 -> lvl 0; 2048+128 -> lvl 1.
- Decay (WIN=4, HOLD_WIN=4, DECAY_WIN=2): one window of lvl 12, then silence.
  - num drops to 0 at the next window; peak stays 12 for 4 windows.
  - peak then reaches 11 after 2 more windows, then 10, down to 0.
  - A lvl-9 window arriving while peak=10 -> peak=9, FSM TRACK.
- Override: ovr_req=1, ovr_num=5 -> ovr_gnt=1 and num=5, peak=0 one cycle later. Change ovr_num to 13 -> num=13 next cycle. Drop ovr_req -> ovr_gnt=0 and num=current meter level next cycle, reflecting windows closed during override.
- Window closes on the same cycle ovr_req rises -> num shows ovr_num next cycle; after release, num equals that window's max.
